// File: rtl/core_alu_pkg.sv
// core_alu_pkg: shared ALU opcodes, datapath defaults and response-register states
package core_alu_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_OP_W = 3;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LAST_LEGAL = 3'b100;
    typedef enum logic {EMPTY, FULL} resp_state_e;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester, shared-ALU and response signals of the ALU share arbiter
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 32,
    parameter int OP_W = 3,
    parameter int ID_W = 2
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0] req_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0] alu_op;
    logic [DATA_W-1:0] alu_result;
    logic resp_valid;
    logic resp_ready;
    logic [DATA_W-1:0] resp_result;
    logic [ID_W-1:0] resp_id;
    logic resp_illegal;
    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, resp_ready,
        input req_ready, alu_a, alu_b, alu_op, resp_valid, resp_result, resp_id, resp_illegal
    );
    modport slave (
        input req_valid, req_a, req_b, req_op, alu_result, resp_ready,
        output req_ready, alu_a, alu_b, alu_op, resp_valid, resp_result, resp_id, resp_illegal
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant searching upward from a pointer that advances past each winner
module rr_arbiter #(
    parameter int N = 4,
    parameter int ID_W = 2
) (
    input logic clk,
    input logic rst,
    input logic [N-1:0] req,
    input logic en,
    output logic [N-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic [ID_W-1:0] ptr,
    output logic xfer
);
    logic hit;
    int c;
    // Scan from farthest to nearest so the requester closest to ptr wins
    always_comb begin
        gnt_idx = ptr;
        hit = 1'b0;
        c = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % N;
            if (req[c]) begin
                gnt_idx = ID_W'(c);
                hit = 1'b1;
            end
        end
    end
    assign xfer = en && hit;
    assign gnt = xfer ? N'(1) << gnt_idx : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else if (xfer) ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU with a one-entry tagged
// response register
module alu_share_arbiter
    import core_alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W = DEF_OP_W,
    parameter int ID_W = 2
) (
    input logic clk,
    input logic rst,
    alu_share_arbiter_if.slave bus
);
    resp_state_e state, state_nx;
    logic can_accept, xfer, illegal;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0] gnt_idx, ptr, sel;
    logic [DATA_W-1:0] result;
    logic [ID_W-1:0] id;
    logic ill;
    assign can_accept = (state == EMPTY) || bus.resp_ready;
    // Grants are suppressed while reset is asserted, independent of the clock
    rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk(clk),
        .rst(rst),
        .req(bus.req_valid),
        .en(can_accept && !rst),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .ptr(ptr),
        .xfer(xfer)
    );
    assign bus.req_ready = gnt;
    assign sel = xfer ? gnt_idx : ptr;
    assign bus.alu_a = bus.req_a[sel*DATA_W +: DATA_W];
    assign bus.alu_b = bus.req_b[sel*DATA_W +: DATA_W];
    assign bus.alu_op = bus.req_op[sel*OP_W +: OP_W];
    assign illegal = bus.alu_op > OP_LAST_LEGAL;
    always_comb begin
        state_nx = state;
        state_nx = xfer ? FULL : (can_accept ? EMPTY : state);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else state <= state_nx;
    end
    // The ALU output is undefined for illegal opcodes, so it is never captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            id <= '0;
            ill <= 1'b0;
        end else if (xfer) begin
            result <= illegal ? '0 : bus.alu_result;
            id <= gnt_idx;
            ill <= illegal;
        end
    end
    assign bus.resp_valid = (state == FULL);
    assign bus.resp_result = result;
    assign bus.resp_id = id;
    assign bus.resp_illegal = ill;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and random stimulus checked against a per-cycle round-robin model
module tb_alu_share_arbiter;
    import core_alu_pkg::*;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    alu_share_arbiter_if #(.NUM_REQ(N), .DATA_W(32), .OP_W(3), .ID_W(2)) bus ();
    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(32), .OP_W(3), .ID_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(logic [31:0] x, logic [31:0] y, logic [2:0] o);
        case (o)
            OP_ADD: return x + y;
            OP_SUB: return x - y;
            OP_AND: return x & y;
            OP_OR: return x | y;
            OP_XOR: return x ^ y;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction
    assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

    logic [31:0] a[N];
    logic [31:0] b[N];
    logic [2:0] op[N];
    logic [N-1:0] v;
    logic rr;
    int ptr = 0;
    bit mv = 0;
    logic [31:0] mres = 0;
    int mid = 0;
    bit mill = 0;
    int g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*32 +: 32] = a[i];
            bus.req_b[i*32 +: 32] = b[i];
            bus.req_op[i*3 +: 3] = op[i];
        end
        bus.req_valid = v;
        bus.resp_ready = rr;
    endtask

    task automatic model_reset();
        ptr = 0;
        mv = 0;
        mres = 0;
        mid = 0;
        mill = 0;
    endtask

    // One clock: drive at negedge, check just after, then advance the model past the next posedge
    task automatic step();
        int sel;
        bit ca;
        @(negedge clk);
        drive();
        #1;
        ca = !mv || rr;
        g = -1;
        if (ca)
            for (int k = 0; k < N; k++)
                if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
        sel = (g >= 0) ? g : ptr;
        chk("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'(1) << g) : 32'(0));
        chk("alu_a", bus.alu_a, a[sel]);
        chk("alu_b", bus.alu_b, b[sel]);
        chk("alu_op", 32'(bus.alu_op), 32'(op[sel]));
        chk("resp_valid", 32'(bus.resp_valid), 32'(mv));
        chk("resp_result", bus.resp_result, mres);
        chk("resp_id", 32'(bus.resp_id), 32'(mid));
        chk("resp_illegal", 32'(bus.resp_illegal), 32'(mill));
        if (g >= 0) begin
            mv = 1;
            mill = op[g] > 3'd4;
            mres = mill ? 32'(0) : alu_f(a[g], b[g], op[g]);
            mid = g;
            ptr = (g + 1) % N;
        end else if (ca) mv = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            a[i] = 0;
            b[i] = 0;
            op[i] = 0;
        end
        v = '1;
        rr = 1'b1;
        drive();
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_valid", 32'(bus.resp_valid), 0);
        chk("rst_result", bus.resp_result, 0);
        chk("rst_id", 32'(bus.resp_id), 0);
        chk("rst_illegal", 32'(bus.resp_illegal), 0);
        v = '0;
        drive();
        rst = 1'b0;

        // Round-robin: grants 0,1,2,3,0,1 with results 9,10,11,12,9 back to back
        for (int i = 0; i < N; i++) begin
            a[i] = 10 + i;
            b[i] = 1;
            op[i] = OP_SUB;
        end
        v = '1;
        for (int j = 0; j < 6; j++) begin
            step();
            chk("rr_grant", 32'(bus.req_ready), 32'(1) << (j % N));
            if (j > 0) chk("rr_result", bus.resp_result, 32'(9 + (j - 1) % N));
        end

        // Single op from requester 2
        v = 4'b0100;
        a[2] = 7;
        b[2] = 5;
        op[2] = OP_ADD;
        step();
        v = '0;
        step();
        chk("single_valid", 32'(bus.resp_valid), 1);
        chk("single_result", bus.resp_result, 12);
        chk("single_id", 32'(bus.resp_id), 2);
        step();
        chk("single_drain", 32'(bus.resp_valid), 0);

        // Wrap and skip from pointer 3 with requesters 1 and 3 valid
        v = 4'b1010;
        step();
        chk("wrap_g3", 32'(bus.req_ready), 8);
        v = 4'b0010;
        step();
        chk("wrap_g1", 32'(bus.req_ready), 2);
        v = '0;
        step();
        v = '1;
        step();
        chk("wrap_ptr2", 32'(bus.req_ready), 4);

        // Backpressure holding result 0xFF from requester 1
        v = 4'b0010;
        a[1] = 32'hF0;
        b[1] = 32'h0F;
        op[1] = OP_OR;
        step();
        v = '1;
        rr = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("bp_ready", 32'(bus.req_ready), 0);
            chk("bp_result", bus.resp_result, 32'hFF);
            chk("bp_id", 32'(bus.resp_id), 1);
        end
        rr = 1'b1;
        step();
        chk("bp_release", 32'(bus.req_ready), 4);
        v = '0;
        step();

        // Illegal opcode from requester 0
        v = 4'b0001;
        a[0] = $urandom;
        b[0] = $urandom;
        op[0] = 3'b110;
        step();
        v = '0;
        step();
        chk("ill_flag", 32'(bus.resp_illegal), 1);
        chk("ill_result", bus.resp_result, 0);
        chk("ill_id", 32'(bus.resp_id), 0);

        // Random traffic; an ungranted valid request keeps its fields
        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < N; i++)
                if (!(v[i] && g != i)) begin
                    v[i] = 1'($urandom_range(0, 1));
                    a[i] = $urandom;
                    b[i] = $urandom;
                    op[i] = 3'($urandom_range(0, 7));
                end
            rr = ($urandom_range(0, 9) < 7);
            step();
        end

        // Asynchronous reset while FULL with requests pending
        v = '1;
        rr = 1'b0;
        step();
        step();
        chk("ar_full", 32'(bus.resp_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(bus.resp_valid), 0);
        chk("ar_ready", 32'(bus.req_ready), 0);
        model_reset();
        @(negedge clk);
        v = '0;
        drive();
        rst = 1'b0;
        v = '1;
        rr = 1'b1;
        step();
        chk("ar_first", 32'(bus.req_ready), 1);
        v = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU among NUM_REQ requesters (for example decode slots, an address generator and a debug port).
- Requesters use a valid/ready handshake. A round-robin arbiter grants one request per cycle and drives the ALU operands and opcode.
- The ALU result is captured into a one-entry response register tagged with the requester ID.
- Sits between the requesters and the ALU instance in the core datapath.

Parameters:
- NUM_REQ, 4, number of requesters; must be 2..8.
- DATA_W, 32, operand and result width.
- OP_W, 3, ALU opcode width.
- ID_W, 2, requester ID width; must be ≥ clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_a  in  NUM_REQ*DATA_W  flattened operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  flattened operand B, same packing as req_a.
- req_op  in  NUM_REQ*OP_W  flattened opcode, same packing.
- alu_a  out  DATA_W  operand A to the shared ALU.
- alu_b  out  DATA_W  operand B to the shared ALU.
- alu_op  out  OP_W  opcode to the shared ALU.
- alu_result  in  DATA_W  ALU result; combinational, same cycle.
- resp_valid  out  1  response register holds data.
- resp_ready  in  1  consumer accepts the response.
- resp_result  out  DATA_W  captured result.
- resp_id  out  ID_W  ID of the requester that owns resp_result.
- resp_illegal  out  1  the captured opcode was not 000–100.

Behaviour:
- Reset (async assert, applied immediately):
  - resp_valid=0, resp_result=0, resp_id=0, resp_illegal=0.
  - Round-robin pointer=0.
  - req_ready all 0 while rst is high.
  - Release of rst is synchronised by the integrator.
- Response register states:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
- can_accept = EMPTY or (FULL and resp_ready). This allows back-to-back operation at 1 op/cycle.
- Grant (combinational):
  - If can_accept, pick the first requester with req_valid=1, searching from the pointer upward with wrap.
  - Assert req_ready only for that requester. A transfer occurs when req_valid & req_ready.
  - If can_accept=0, all req_ready=0.
- ALU drive:
  - alu_a/alu_b/alu_op = the granted requester's fields.
  - With no grant, drive the fields of requester at the pointer index, so the ALU inputs never float or glitch to X.
- Capture on the transfer edge:
  - resp_result <= alu_result, or 0 if the opcode is 101–111. The ALU output is undefined for those codes, so it is never captured.
  - resp_id <= granted index.
  - resp_illegal <= (op > 100).
  - resp_valid <= 1.
- Latency: 1 cycle from the accepted request to resp_valid.
- Drain: if FULL, resp_ready=1 and no new transfer, resp_valid <= 0. resp_result and resp_id hold their last values.
- Backpressure: if FULL and resp_ready=0, the response fields are held stable and no grant is issued.
- Pointer update: on a transfer from requester g, pointer <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0. With no transfer, the pointer is unchanged.
- Fairness: a continuously asserted request is granted within NUM_REQ accepted transfers.
- Requester rule: req_* must stay stable while req_valid=1 and not yet granted. The block does not check this.
- Simultaneous drain and capture in one cycle: new data is loaded and resp_valid stays 1.
- Reset mid-operation: a pending response is discarded. Requesters must re-present it, since their request was already consumed.

Decomposition:
- Shared package core_alu_pkg holds:
  - ALU opcode constants: OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_LAST_LEGAL=100.
  - DATA_W and OP_W defaults.
- One sub-module: rr_arbiter.
  - Inputs: req vector, enable (can_accept).
  - Outputs: one-hot grant and grant index.
  - Owns the pointer register with the async reset.
- The response register and operand mux stay in the top module.

Test Plan:
- Single op: requester 2 sends a=7, b=5, op=000, with resp_ready=1.
  - Next cycle: resp_valid=1, resp_result=12, resp_id=2, resp_illegal=0.
  - Following cycle with no new request: resp_valid=0.
- Round-robin: all 4 requesters hold req_valid=1 with op=001, a=10+i, b=1.
  - Grants go 0,1,2,3,0.
  - Results are 9,10,11,12, one per cycle with no bubbles.
- Backpressure: with resp FULL (result 0x0000_00FF, id 1), hold resp_ready=0 for 3 cycles.
  - req_ready stays 0 throughout; resp fields are stable.
  - When resp_ready rises, the next grant appears in the same cycle.
- Illegal opcode: requester 0 sends op=110.
  - resp_illegal=1, resp_result=0, resp_id=0.
- Wrap and skip: with the pointer at 3, only requesters 1 and 3 are valid.
  - Grants are 3 then 1; the pointer ends at 2.
- Async reset while FULL and requests pending: assert rst between clock edges.
  - resp_valid and req_ready drop immediately.
  - After release, the first grant goes to requester 0.
